midi_btn_note_encoder: RTL and testbench
========================================

Name: midi_btn_note_encoder

Overview:
- Consumes the debounced button levels produced by the debounce stage and turns every change of button state into a MIDI Note On or Note Off message.
- Serialises each message byte-wise over a valid/ready stream to the downstream MIDI UART transmitter.
- Tracks the last reported state of every button.
  - Any button whose current state differs from its reported state is pending.
  - Pending buttons are served lowest index first.

Parameters:
- NBTN, 8: number of buttons, 1..16.
- BASE_NOTE, 60: note number sent for button 0; button i sends BASE_NOTE+i. Requires BASE_NOTE+NBTN <= 128; otherwise elaboration error.
- CHANNEL, 0: MIDI channel, 0..15, placed in the status low nibble.
- VELOCITY, 100: Note On velocity, 1..127.
- RUNNING_STATUS, 0: 1 = omit the status byte when it equals the last status byte sent.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- btn_pressed  in  NBTN  debounced button levels, 1 = pressed; synchronous to clk.
- tx_data  out  8  MIDI byte to the transmitter.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  transmitter accepts the byte in this cycle.
- busy  out  1  a message is in progress (state != IDLE).

Behaviour:
- Reset, asynchronous, active-high. All of the following take effect immediately, including mid-message:
  - state=IDLE, tx_valid=0, tx_data=0x00, busy=0.
  - reported[NBTN-1:0]=0.
  - last_status marked invalid; the message in progress is discarded, with no partial completion.
- pending = btn_pressed ^ reported, evaluated combinationally each cycle.
- FSM states: IDLE, STATUS, NOTE, VEL.
- IDLE:
  - If pending is nonzero, pick the lowest set index i.
  - Latch idx=i and on=btn_pressed[i].
  - Set reported[i] <= btn_pressed[i] in the same cycle.
  - Compute status = (on ? 0x90 : 0x80) | CHANNEL.
  - Go to NOTE if RUNNING_STATUS=1, last_status is valid and status == last_status; otherwise go to STATUS.
  - If pending is zero, stay in IDLE with tx_valid=0.
- STATUS: tx_valid=1, tx_data=status. On tx_ready: last_status <= status (valid), go to NOTE.
- NOTE: tx_valid=1, tx_data = {0, BASE_NOTE+idx} (7-bit). On tx_ready, go to VEL.
- VEL: tx_valid=1, tx_data = on ? VELOCITY : 0x00. On tx_ready, go to IDLE.
- Handshake:
  - A byte transfers when tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_valid stays 1 and tx_data holds stable; valid is never withdrawn.
  - tx_valid and tx_data are registered outputs.
- Latency and cycle timing:
  - A change on btn_pressed in cycle k, with the FSM in IDLE, gives tx_valid=1 on the first byte from cycle k+1.
  - Back-to-back messages are separated by exactly one IDLE cycle with tx_valid=0.
- Changes during a message:
  - A button other than idx that changes during a message stays pending and is served afterwards.
  - If button idx itself changes again during its own message, it becomes pending again and is sent after this message completes.
  - A button that toggles and returns to its reported state before the FSM reaches IDLE produces no message.
- Simultaneous changes: served in ascending index order, one full message each.
- Running status: last_status is updated only when a status byte is actually transferred. It is never updated by reported[] alone.
- After reset release:
  - Buttons held at 1 become pending and each emits a Note On.
  - With RUNNING_STATUS=1, the first message after reset always includes its status byte.
- tx_ready asserted while tx_valid=0 is ignored.

Test Plan:
- All tests use NBTN=8, BASE_NOTE=60, CHANNEL=0, VELOCITY=100 unless stated.
- Basic press/release: tx_ready=1, set btn_pressed[2] -> bytes 0x90,0x3E,0x64; tx_valid first rises the cycle after the edge. Clear bit 2 -> 0x80,0x3E,0x00.
- Simultaneous presses: btn_pressed 0x00 -> 0x22 in one cycle.
  - RUNNING_STATUS=0 -> 0x90,0x3D,0x64, one idle cycle, then 0x90,0x41,0x64.
  - RUNNING_STATUS=1 -> 0x90,0x3D,0x64 then 0x41,0x64.
- Backpressure: hold tx_ready=0 for 10 cycles while in NOTE for button 2 -> tx_valid stays 1 and tx_data=0x3E stable for all 10 cycles. Releasing tx_ready completes 0x3E then 0x64.
- Transient cancel: during a slow-ready message for button 3, pulse btn_pressed[0] high for 3 cycles, returning low before the message ends -> no message for button 0; busy drops after 0x64.
- Reset mid-message: assert rst in NOTE with btn_pressed[2]=1 and RUNNING_STATUS=1 -> tx_valid=0 and busy=0 in the same cycle. After rst release -> full 0x90,0x3E,0x64, with the status byte not omitted.
- Running-status switch: RUNNING_STATUS=1, press then release button 7 -> 0x90,0x43,0x64 then 0x80,0x43,0x00; the status byte is resent because it changed.

Source files
------------

// File: rtl/midi_btn_note_encoder_if.sv
// Byte stream from the note encoder to the MIDI UART transmitter.
interface midi_btn_note_encoder_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/midi_btn_note_encoder.sv
// Turns debounced button level changes into MIDI Note On/Off messages,
// serialised one byte at a time over a valid/ready stream.
module midi_btn_note_encoder #(
    parameter int NBTN           = 8,
    parameter int BASE_NOTE      = 60,
    parameter int CHANNEL        = 0,
    parameter int VELOCITY       = 100,
    parameter int RUNNING_STATUS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBTN-1:0]          btn_pressed,
    midi_btn_note_encoder_if.master  tx,
    output logic                     busy
);
    localparam int IW = (NBTN > 1) ? $clog2(NBTN) : 1;

    generate
        if (NBTN < 1 || NBTN > 16) begin : g_bad_nbtn
            $error("NBTN must be 1..16");
        end
        if (BASE_NOTE < 0 || BASE_NOTE + NBTN > 128) begin : g_bad_note
            $error("BASE_NOTE+NBTN must not exceed 128");
        end
        if (CHANNEL < 0 || CHANNEL > 15) begin : g_bad_chan
            $error("CHANNEL must be 0..15");
        end
        if (VELOCITY < 1 || VELOCITY > 127) begin : g_bad_vel
            $error("VELOCITY must be 1..127");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

    state_t          state, state_n;
    logic [NBTN-1:0] reported, reported_n;
    logic [NBTN-1:0] pending;
    logic [IW-1:0]   idx, idx_n, pick;
    logic            on, on_n;
    logic [7:0]      last_status, last_status_n, new_status;
    logic            ls_valid, ls_valid_n;
    logic [7:0]      data_q, data_n;
    logic            valid_q, valid_n;

    function automatic logic [7:0] status_of(input logic o);
        return {(o ? 4'h9 : 4'h8), 4'(CHANNEL)};
    endfunction

    function automatic logic [7:0] note_of(input logic [IW-1:0] i);
        return 8'(BASE_NOTE) + 8'(i);
    endfunction

    assign pending     = btn_pressed ^ reported;
    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = (state != IDLE);

    // Descending scan so the lowest pending index wins.
    always_comb begin
        pick = '0;
        for (int i = NBTN - 1; i >= 0; i--)
            if (pending[i]) pick = IW'(i);
    end

    always_comb begin
        state_n       = state;
        reported_n    = reported;
        idx_n         = idx;
        on_n          = on;
        last_status_n = last_status;
        ls_valid_n    = ls_valid;
        data_n        = data_q;
        valid_n       = valid_q;
        new_status    = status_of(btn_pressed[pick]);
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                data_n  = 8'h00;
                if (|pending) begin
                    idx_n            = pick;
                    on_n             = btn_pressed[pick];
                    reported_n[pick] = btn_pressed[pick];
                    valid_n          = 1'b1;
                    if (RUNNING_STATUS != 0 && ls_valid && new_status == last_status) begin
                        state_n = NOTE;
                        data_n  = note_of(pick);
                    end else begin
                        state_n = STATUS;
                        data_n  = new_status;
                    end
                end
            end
            STATUS: if (tx.tx_ready) begin
                last_status_n = status_of(on);
                ls_valid_n    = 1'b1;
                state_n       = NOTE;
                data_n        = note_of(idx);
            end
            NOTE: if (tx.tx_ready) begin
                state_n = VEL;
                data_n  = on ? 8'(VELOCITY) : 8'h00;
            end
            VEL: if (tx.tx_ready) begin
                state_n = IDLE;
                valid_n = 1'b0;
                data_n  = 8'h00;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            reported    <= '0;
            idx         <= '0;
            on          <= 1'b0;
            last_status <= 8'h00;
            ls_valid    <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            state       <= state_n;
            reported    <= reported_n;
            idx         <= idx_n;
            on          <= on_n;
            last_status <= last_status_n;
            ls_valid    <= ls_valid_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
        end
    end
endmodule

// File: tb/tb_midi_btn_note_encoder.sv
// Directed bench: one encoder without and one with running status.
module tb_midi_btn_note_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn0, btn1;
    logic       busy0, busy1;
    int         checks = 0;
    int         passes = 0;

    midi_btn_note_encoder_if bus0();
    midi_btn_note_encoder_if bus1();

    midi_btn_note_encoder #(.RUNNING_STATUS(0)) dut0 (
        .clk(clk), .rst(rst), .btn_pressed(btn0), .tx(bus0), .busy(busy0));
    midi_btn_note_encoder #(.RUNNING_STATUS(1)) dut1 (
        .clk(clk), .rst(rst), .btn_pressed(btn1), .tx(bus1), .busy(busy1));

    always #5 clk = ~clk;

    // Waits for the next accepted byte; waited is the number of cycles taken, -1 on timeout.
    task automatic get_byte(input int sel, output logic [7:0] b, output int waited);
        b = 8'h00;
        waited = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (sel == 0 ? (bus0.tx_valid && bus0.tx_ready) : (bus1.tx_valid && bus1.tx_ready)) begin
                b = (sel == 0) ? bus0.tx_data : bus1.tx_data;
                waited = n;
                return;
            end
        end
    endtask

    task automatic drain();
        bus0.tx_ready = 1'b1;
        bus1.tx_ready = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn0 = 8'h00; btn1 = 8'h00;
        bus0.tx_ready = 1'b0; bus1.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.tx_valid, bus0.tx_data, busy0} !== 10'h0) $display("FAIL reset0: got v=%b d=%h busy=%b want 0/00/0", bus0.tx_valid, bus0.tx_data, busy0);
        else passes++;
        checks++;
        if ({bus1.tx_valid, bus1.tx_data, busy1} !== 10'h0) $display("FAIL reset1: got v=%b d=%h busy=%b want 0/00/0", bus1.tx_valid, bus1.tx_data, busy1);
        else passes++;
        rst = 1'b0;
        bus0.tx_ready = 1'b1; bus1.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.tx_valid !== 1'b0 || busy0 !== 1'b0) $display("FAIL idle_ready: got v=%b busy=%b want 0/0", bus0.tx_valid, busy0);
            else passes++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [6] = '{8'h90, 8'h3E, 8'h64, 8'h80, 8'h3E, 8'h00};
        logic [7:0] b;
        int w;
        @(negedge clk);
        btn0 = 8'h04;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                @(negedge clk);
                checks++;
                if (busy0 !== 1'b0 || bus0.tx_valid !== 1'b0) $display("FAIL basic_idle: got busy=%b v=%b want 0/0", busy0, bus0.tx_valid);
                else passes++;
                btn0 = 8'h00;
            end
            get_byte(0, b, w);
            checks++;
            if (b !== exp[k] || w !== 1) $display("FAIL basic[%0d]: got %h after %0d want %h after 1", k, b, w, exp[k]);
            else passes++;
        end
    endtask

    task automatic test_simultaneous_rs0();
        logic [7:0] exp [6] = '{8'h90, 8'h3D, 8'h64, 8'h90, 8'h41, 8'h64};
        int ew [6] = '{1, 1, 1, 2, 1, 1};
        logic [7:0] b;
        int w;
        @(negedge clk);
        btn0 = 8'h22;
        for (int k = 0; k < 6; k++) begin
            get_byte(0, b, w);
            checks++;
            if (b !== exp[k] || w !== ew[k]) $display("FAIL sim_rs0[%0d]: got %h after %0d want %h after %0d", k, b, w, exp[k], ew[k]);
            else passes++;
        end
        btn0 = 8'h00;
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        int w;
        @(negedge clk);
        btn0 = 8'h04;
        get_byte(0, b, w);
        checks++;
        if (b !== 8'h90 || w !== 1) $display("FAIL bp_status: got %h after %0d want 90 after 1", b, w);
        else passes++;
        @(negedge clk);
        bus0.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.tx_valid !== 1'b1 || bus0.tx_data !== 8'h3E) $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1/3e", i, bus0.tx_valid, bus0.tx_data);
            else passes++;
        end
        bus0.tx_ready = 1'b1;
        checks++;
        if (bus0.tx_valid !== 1'b1 || bus0.tx_data !== 8'h3E) $display("FAIL bp_note: got v=%b d=%h want 1/3e", bus0.tx_valid, bus0.tx_data);
        else passes++;
        get_byte(0, b, w);
        checks++;
        if (b !== 8'h64 || w !== 1) $display("FAIL bp_vel: got %h after %0d want 64 after 1", b, w);
        else passes++;
        btn0 = 8'h00;
        drain();
    endtask

    task automatic test_transient();
        logic [7:0] b;
        int w;
        @(negedge clk);
        btn0 = 8'h08;
        bus0.tx_ready = 1'b0;
        @(negedge clk);
        btn0 = 8'h09;
        repeat (3) @(negedge clk);
        btn0 = 8'h08;
        @(negedge clk);
        bus0.tx_ready = 1'b1;
        checks++;
        if (bus0.tx_valid !== 1'b1 || bus0.tx_data !== 8'h90) $display("FAIL tr_status: got v=%b d=%h want 1/90", bus0.tx_valid, bus0.tx_data);
        else passes++;
        get_byte(0, b, w);
        checks++;
        if (b !== 8'h3F || w !== 1) $display("FAIL tr_note: got %h after %0d want 3f after 1", b, w);
        else passes++;
        get_byte(0, b, w);
        checks++;
        if (b !== 8'h64 || w !== 1) $display("FAIL tr_vel: got %h after %0d want 64 after 1", b, w);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.tx_valid !== 1'b0 || busy0 !== 1'b0) $display("FAIL tr_quiet[%0d]: got v=%b busy=%b want 0/0", i, bus0.tx_valid, busy0);
            else passes++;
        end
        btn0 = 8'h00;
        drain();
    endtask

    task automatic test_simultaneous_rs1();
        logic [7:0] exp [5] = '{8'h90, 8'h3D, 8'h64, 8'h41, 8'h64};
        int ew [5] = '{1, 1, 1, 2, 1};
        logic [7:0] b;
        int w;
        @(negedge clk);
        btn1 = 8'h22;
        for (int k = 0; k < 5; k++) begin
            get_byte(1, b, w);
            checks++;
            if (b !== exp[k] || w !== ew[k]) $display("FAIL sim_rs1[%0d]: got %h after %0d want %h after %0d", k, b, w, exp[k], ew[k]);
            else passes++;
        end
        btn1 = 8'h00;
        drain();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [3] = '{8'h90, 8'h3E, 8'h64};
        logic [7:0] b;
        int w;
        @(negedge clk);
        btn1 = 8'h04;
        get_byte(1, b, w);
        checks++;
        if (b !== 8'h90 || w !== 1) $display("FAIL rm_first: got %h after %0d want 90 after 1", b, w);
        else passes++;
        @(negedge clk);
        bus1.tx_ready = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || bus1.tx_data !== 8'h3E) $display("FAIL rm_in_note: got busy=%b d=%h want 1/3e", busy1, bus1.tx_data);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (bus1.tx_valid !== 1'b0 || busy1 !== 1'b0 || bus1.tx_data !== 8'h00) $display("FAIL rm_async: got v=%b busy=%b d=%h want 0/0/00", bus1.tx_valid, busy1, bus1.tx_data);
        else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus1.tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_byte(1, b, w);
            checks++;
            if (b !== exp[k] || w !== 1) $display("FAIL rm_after[%0d]: got %h after %0d want %h after 1", k, b, w, exp[k]);
            else passes++;
        end
    endtask

    task automatic test_rs_switch();
        logic [7:0] exp [9] = '{8'h80, 8'h3E, 8'h00, 8'h90, 8'h43, 8'h64, 8'h80, 8'h43, 8'h00};
        logic [7:0] pat [3] = '{8'h00, 8'h80, 8'h00};
        logic [7:0] b;
        int w;
        for (int k = 0; k < 9; k++) begin
            if (k % 3 == 0) begin
                @(negedge clk);
                btn1 = pat[k / 3];
            end
            get_byte(1, b, w);
            checks++;
            if (b !== exp[k] || w !== 1) $display("FAIL rs_switch[%0d]: got %h after %0d want %h after 1", k, b, w, exp[k]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous_rs0();
        test_backpressure();
        test_transient();
        test_simultaneous_rs1();
        test_reset_mid();
        test_rs_switch();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
